jt49_ncore: RTL



---
 rtl/jt49_ncore_if.sv | 11 +
 rtl/jt49_ncore.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_ncore_if.sv
// Sound-CPU register bus for jt49_ncore: level-sensitive write strobe,
// 5-bit address, 8-bit write data and registered read data.
interface jt49_ncore_if;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output wr, output addr, output din, input dout);
    modport slave  (input wr, input addr, input din, output dout);
endinterface

// File: rtl/jt49_ncore.sv
// jt49_ncore: NCH square-wave tone channels, shared 17-bit LFSR noise and a
// time-multiplexed log-volume mixer. Define JT49_NCORE_STEREO_EN for snd_l/snd_r.
module jt49_ncore #(
    parameter int NCH  = 3,
    parameter int PW   = 12,
    parameter int PRE  = 16,
    parameter int OUTW = 8 + $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    jt49_ncore_if.slave     bus,
    output logic [OUTW-1:0] snd,
`ifdef JT49_NCORE_STEREO_EN
    output logic [OUTW-1:0] snd_l,
    output logic [OUTW-1:0] snd_r,
`endif
    output logic            sample
);

    localparam int PREW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int SW   = $clog2(NCH + 1);

    function automatic logic [7:0] vol_lin(input logic [3:0] v);
        case (v)
            4'd0:  return 8'd0;
            4'd1:  return 8'd2;
            4'd2:  return 8'd3;
            4'd3:  return 8'd4;
            4'd4:  return 8'd5;
            4'd5:  return 8'd8;
            4'd6:  return 8'd11;
            4'd7:  return 8'd16;
            4'd8:  return 8'd22;
            4'd9:  return 8'd32;
            4'd10: return 8'd45;
            4'd11: return 8'd64;
            4'd12: return 8'd90;
            4'd13: return 8'd127;
            4'd14: return 8'd180;
            default: return 8'd255;
        endcase
    endfunction

    // A counter wraps once cnt+1 reaches the period, so a period written
    // below the running count fires on the very next tick.
    function automatic logic tone_wrap(input logic [PW-1:0] cnt, input logic [PW-1:0] per);
        logic [PW:0] nxt;
        logic [PW:0] lim;
        nxt = {1'b0, cnt} + (PW+1)'(1);
        lim = (per == '0) ? (PW+1)'(1) : {1'b0, per};
        return nxt >= lim;
    endfunction

    function automatic logic noise_wrap(input logic [4:0] cnt, input logic [4:0] per);
        logic [5:0] nxt;
        logic [5:0] lim;
        nxt = {1'b0, cnt} + 6'd1;
        lim = (per == 5'd0) ? 6'd1 : {1'b0, per};
        return nxt >= lim;
    endfunction

    logic [PW-1:0]  period [NCH];
    logic [3:0]     vol    [NCH];
    logic [NCH-1:0] tmask;
    logic [NCH-1:0] nmask;
    logic [4:0]     nper;
`ifdef JT49_NCORE_STEREO_EN
    logic [NCH-1:0] lmask;
    logic [NCH-1:0] rmask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                period[k] <= '0;
                vol[k]    <= '0;
            end
            tmask <= '0;
            nmask <= '0;
            nper  <= '0;
`ifdef JT49_NCORE_STEREO_EN
            lmask <= '1;
            rmask <= '1;
`endif
        end else if (bus.wr) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.addr == 5'(2*k))    period[k][7:0]    <= bus.din;
                if (bus.addr == 5'(2*k+1))  period[k][PW-1:8] <= bus.din[PW-9:0];
                if (bus.addr == 5'(16+k))   vol[k]            <= bus.din[3:0];
            end
            case (bus.addr)
                5'h18: tmask <= bus.din[NCH-1:0];
                5'h19: nmask <= bus.din[NCH-1:0];
                5'h1A: nper  <= bus.din[4:0];
`ifdef JT49_NCORE_STEREO_EN
                5'h1B: lmask <= bus.din[NCH-1:0];
                5'h1C: rmask <= bus.din[NCH-1:0];
`endif
                default: ;
            endcase
        end
    end

    logic [7:0] rdata;

    always_comb begin
        rdata = 8'd0;
        for (int k = 0; k < NCH; k++) begin
            if (bus.addr == 5'(2*k))   rdata = period[k][7:0];
            if (bus.addr == 5'(2*k+1)) rdata = 8'(period[k] >> 8);
            if (bus.addr == 5'(16+k))  rdata = {4'd0, vol[k]};
        end
        case (bus.addr)
            5'h18: rdata = 8'(tmask);
            5'h19: rdata = 8'(nmask);
            5'h1A: rdata = {3'd0, nper};
`ifdef JT49_NCORE_STEREO_EN
            5'h1B: rdata = 8'(lmask);
            5'h1C: rdata = 8'(rmask);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) bus.dout <= 8'd0;
        else     bus.dout <= rdata;
    end

    logic [PREW-1:0] pcnt;
    logic            tick;

    assign tick = cen && (pcnt == PREW'(PRE-1));

    always_ff @(posedge clk) begin
        if (rst)      pcnt <= '0;
        else if (cen) pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    logic [PW-1:0]  tcnt [NCH];
    logic [NCH-1:0] tone;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) tcnt[k] <= '0;
            tone <= '0;
        end else if (tick) begin
            for (int k = 0; k < NCH; k++) begin
                if (tone_wrap(tcnt[k], period[k])) begin
                    tcnt[k] <= '0;
                    tone[k] <= ~tone[k];
                end else begin
                    tcnt[k] <= tcnt[k] + 1'b1;
                end
            end
        end
    end

    logic [4:0]  ncnt;
    logic [16:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ncnt <= '0;
            lfsr <= 17'h00001;
        end else begin
            if (tick) begin
                if (noise_wrap(ncnt, nper)) begin
                    ncnt <= '0;
                    lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
                end else begin
                    ncnt <= ncnt + 1'b1;
                end
            end
            // Lock-up guard: an all-zero LFSR would never leave that state.
            if (lfsr == '0) lfsr <= 17'h00001;
        end
    end

    logic [NCH-1:0] mix;
    logic [SW-1:0]  slot;
    logic [7:0]     lin_p0;
`ifdef JT49_NCORE_STEREO_EN
    logic [7:0]     lin_l_p0;
    logic [7:0]     lin_r_p0;
`endif

    assign mix = (tone | tmask) & ({NCH{lfsr[0]}} | nmask);

    // Stage p0: pick the linear level of the channel owning the current slot.
    always_comb begin
        lin_p0 = 8'd0;
`ifdef JT49_NCORE_STEREO_EN
        lin_l_p0 = 8'd0;
        lin_r_p0 = 8'd0;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (slot == SW'(k) && mix[k]) begin
                lin_p0 = vol_lin(vol[k]);
`ifdef JT49_NCORE_STEREO_EN
                if (lmask[k]) lin_l_p0 = vol_lin(vol[k]);
                if (rmask[k]) lin_r_p0 = vol_lin(vol[k]);
`endif
            end
        end
    end

    logic [OUTW-1:0] acc_p1;
`ifdef JT49_NCORE_STEREO_EN
    logic [OUTW-1:0] acc_l_p1;
    logic [OUTW-1:0] acc_r_p1;
`endif

    // Stage p1: accumulate one slot per cen; the extra slot NCH publishes the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot   <= '0;
            acc_p1 <= '0;
            snd    <= '0;
            sample <= 1'b0;
`ifdef JT49_NCORE_STEREO_EN
            acc_l_p1 <= '0;
            acc_r_p1 <= '0;
            snd_l    <= '0;
            snd_r    <= '0;
`endif
        end else begin
            sample <= 1'b0;
            if (cen) begin
                if (slot == SW'(NCH)) begin
                    slot   <= '0;
                    acc_p1 <= '0;
                    snd    <= acc_p1;
                    sample <= 1'b1;
`ifdef JT49_NCORE_STEREO_EN
                    acc_l_p1 <= '0;
                    acc_r_p1 <= '0;
                    snd_l    <= acc_l_p1;
                    snd_r    <= acc_r_p1;
`endif
                end else begin
                    slot   <= slot + 1'b1;
                    acc_p1 <= acc_p1 + OUTW'(lin_p0);
`ifdef JT49_NCORE_STEREO_EN
                    acc_l_p1 <= acc_l_p1 + OUTW'(lin_l_p0);
                    acc_r_p1 <= acc_r_p1 + OUTW'(lin_r_p0);
`endif
                end
            end
        end
    end

endmodule
